// File: rtl/stream_sort_pkg.sv
// stream_sort_pkg: shared state encoding and pad-value helper for stream_sorter.
// Optional build macro: STREAM_SORT_SIGNED_EN (two's-complement compare and pads).
package stream_sort_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SORT = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Widest word the pad helper can describe; callers cast down to their width.
  localparam int unsigned PAD_MAX_W = 256;

  // Pad word that always sorts to the tail for the chosen direction.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input logic descend, input int unsigned data_w);
    logic [PAD_MAX_W-1:0] mask;
    logic [PAD_MAX_W-1:0] msb;
    logic [PAD_MAX_W-1:0] v;
    mask = {PAD_MAX_W{1'b1}} >> (PAD_MAX_W - data_w);
    msb  = {{(PAD_MAX_W-1){1'b0}}, 1'b1} << (data_w - 1);
    v    = descend ? '0 : mask;
`ifdef STREAM_SORT_SIGNED_EN
    // Signed extremes differ from the unsigned ones only in the sign bit.
    v = v ^ msb;
`else
    v = v | (msb & ~msb);
`endif
    return v;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: one combinational compare-swap cell of the transposition network.
// Signedness of the comparison is decided here only (STREAM_SORT_SIGNED_EN).
module sort_cmp_swap #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              descend,
  output logic [DATA_W-1:0] out_lo,
  output logic [DATA_W-1:0] out_hi
);

  logic a_gt_b;
  logic b_gt_a;
  logic swap;

`ifdef STREAM_SORT_SIGNED_EN
  assign a_gt_b = $signed(in_a) > $signed(in_b);
  assign b_gt_a = $signed(in_b) > $signed(in_a);
`else
  assign a_gt_b = in_a > in_b;
  assign b_gt_a = in_b > in_a;
`endif

  // Swap only on strict disorder so equal words keep their slots.
  assign swap   = descend ? b_gt_a : a_gt_b;
  assign out_lo = swap ? in_b : in_a;
  assign out_hi = swap ? in_a : in_b;

endmodule

// File: rtl/stream_sorter.sv
// stream_sorter: AXI-Stream frame sorter using odd-even transposition, one pass per cycle.
// Optional build macro: STREAM_SORT_SIGNED_EN (signed compare, signed pad values).
module stream_sorter #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 10,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic              ap_start,
  input  logic              descend,
  output logic              ap_idle,
  output logic              ap_done,
  output logic [CNT_W-1:0]  frame_len,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  input  logic              sm_tready,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast
);

  import stream_sort_pkg::*;

  localparam int NU = DEPTH / 2;        // compare-swap cells (even pass uses all)
  localparam int NO = (DEPTH - 1) / 2;  // pairs active on odd passes

  state_t            state_reg;
  logic              descend_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  pass_reg;
  logic [CNT_W-1:0]  idx_reg;
  logic [CNT_W-1:0]  idx_next;
  logic [CNT_W-1:0]  frame_len_reg;
  logic              ss_tready_reg;
  logic              sm_tvalid_reg;
  logic [DATA_W-1:0] sm_tdata_reg;
  logic              sm_tlast_reg;
  logic              ap_done_reg;
  logic              ap_idle_reg;
  logic [DATA_W-1:0] pad_word;
  logic              odd_pass;

  logic [DATA_W-1:0] arr_reg  [DEPTH];
  logic [DATA_W-1:0] arr_pass [DEPTH];
  logic [DATA_W-1:0] unit_a   [NU];
  logic [DATA_W-1:0] unit_b   [NU];
  logic [DATA_W-1:0] unit_lo  [NU];
  logic [DATA_W-1:0] unit_hi  [NU];

  assign pad_word = DATA_W'(pad_value(descend, DATA_W));
  assign odd_pass = pass_reg[0];
  assign idx_next = idx_reg + CNT_W'(1);

  // Each cell serves pair (2k,2k+1) on even passes and (2k+1,2k+2) on odd passes.
  for (genvar gi = 0; gi < NU; gi++) begin : g_unit
    if (2 * gi + 2 < DEPTH) begin : g_full
      assign unit_a[gi] = odd_pass ? arr_reg[2*gi+1] : arr_reg[2*gi];
      assign unit_b[gi] = odd_pass ? arr_reg[2*gi+2] : arr_reg[2*gi+1];
    end else begin : g_even_only
      assign unit_a[gi] = arr_reg[2*gi];
      assign unit_b[gi] = arr_reg[2*gi+1];
    end
    sort_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
      .in_a    (unit_a[gi]),
      .in_b    (unit_b[gi]),
      .descend (descend_reg),
      .out_lo  (unit_lo[gi]),
      .out_hi  (unit_hi[gi])
    );
  end

  // Route cell results back to slots; slots outside any pair keep their value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elem
    localparam bit EV_IN = (gi / 2) < NU;
    localparam int EK    = EV_IN ? gi / 2 : 0;
    localparam bit OD_LO = (gi % 2 == 1) && ((gi - 1) / 2 < NO);
    localparam bit OD_HI = (gi >= 2) && (gi % 2 == 0);
    localparam int OKL   = OD_LO ? (gi - 1) / 2 : 0;
    localparam int OKH   = OD_HI ? (gi - 2) / 2 : 0;
    logic [DATA_W-1:0] even_val;
    logic [DATA_W-1:0] odd_val;
    assign even_val     = EV_IN ? ((gi % 2 == 0) ? unit_lo[EK] : unit_hi[EK]) : arr_reg[gi];
    assign odd_val      = OD_LO ? unit_lo[OKL] : (OD_HI ? unit_hi[OKH] : arr_reg[gi]);
    assign arr_pass[gi] = odd_pass ? odd_val : even_val;
  end

  // Frame sequencer: load, sort passes, drain, done pulse; all outputs registered.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_reg     <= ST_IDLE;
      descend_reg   <= 1'b0;
      cnt_reg       <= '0;
      pass_reg      <= '0;
      idx_reg       <= '0;
      frame_len_reg <= '0;
      ss_tready_reg <= 1'b0;
      sm_tvalid_reg <= 1'b0;
      sm_tdata_reg  <= '0;
      sm_tlast_reg  <= 1'b0;
      ap_done_reg   <= 1'b0;
      ap_idle_reg   <= 1'b1;
      for (int i = 0; i < DEPTH; i++) arr_reg[i] <= '0;
    end else begin
      ap_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ap_start) begin
            descend_reg   <= descend;
            cnt_reg       <= '0;
            frame_len_reg <= '0;
            ss_tready_reg <= 1'b1;
            ap_idle_reg   <= 1'b0;
            state_reg     <= ST_LOAD;
            for (int i = 0; i < DEPTH; i++) arr_reg[i] <= pad_word;
          end
        end
        ST_LOAD: begin
          if (ss_tvalid) begin
            arr_reg[cnt_reg] <= ss_tdata;
            cnt_reg          <= cnt_reg + CNT_W'(1);
            if (ss_tlast || cnt_reg == CNT_W'(DEPTH - 1)) begin
              frame_len_reg <= cnt_reg + CNT_W'(1);
              ss_tready_reg <= 1'b0;
              pass_reg      <= '0;
              state_reg     <= ST_SORT;
            end
          end
        end
        ST_SORT: begin
          for (int i = 0; i < DEPTH; i++) arr_reg[i] <= arr_pass[i];
          pass_reg <= pass_reg + CNT_W'(1);
          if (pass_reg == CNT_W'(DEPTH - 1)) begin
            idx_reg       <= '0;
            sm_tvalid_reg <= 1'b1;
            sm_tdata_reg  <= arr_pass[0];
            sm_tlast_reg  <= (frame_len_reg == CNT_W'(1));
            state_reg     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (sm_tready) begin
            if (idx_reg == frame_len_reg - CNT_W'(1)) begin
              sm_tvalid_reg <= 1'b0;
              sm_tdata_reg  <= '0;
              sm_tlast_reg  <= 1'b0;
              ap_done_reg   <= 1'b1;
              state_reg     <= ST_DONE;
            end else begin
              idx_reg      <= idx_next;
              sm_tdata_reg <= arr_reg[idx_next];
              sm_tlast_reg <= (idx_reg + CNT_W'(2) == frame_len_reg);
            end
          end
        end
        ST_DONE: begin
          ap_idle_reg <= 1'b1;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ss_tready = ss_tready_reg;
  assign sm_tvalid = sm_tvalid_reg;
  assign sm_tdata  = sm_tdata_reg;
  assign sm_tlast  = sm_tlast_reg;
  assign ap_done   = ap_done_reg;
  assign ap_idle   = ap_idle_reg;
  assign frame_len = frame_len_reg;

endmodule

// File: tb/tb_stream_sorter.sv
// tb_stream_sorter: directed frames against a queue-based sorting model of stream_sorter.
`timescale 1ns/1ps
module tb_stream_sorter;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 10;
  localparam int CNT_W  = $clog2(DEPTH + 1);

`ifdef STREAM_SORT_SIGNED_EN
  typedef int word_t;
`else
  typedef int unsigned word_t;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                len;
  } exp_t;

  logic              axis_clk = 1'b0;
  logic              axis_rst;
  logic              ap_start;
  logic              descend;
  logic              ap_idle;
  logic              ap_done;
  logic [CNT_W-1:0]  frame_len;
  logic              ss_tvalid;
  logic [DATA_W-1:0] ss_tdata;
  logic              ss_tlast;
  logic              ss_tready;
  logic              sm_tready;
  logic              sm_tvalid;
  logic [DATA_W-1:0] sm_tdata;
  logic              sm_tlast;

  int n_checks = 0;
  int n_fail   = 0;
  bit bp_en    = 1'b0;

  word_t             cur_q[$];
  exp_t              exp_q[$];
  logic [DATA_W-1:0] out_log[$];
  logic              model_desc = 1'b0;
  exp_t              e;
  bit                prev_stall, prev_last_hs, prev_done, cur_hs;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  stream_sorter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .ap_start  (ap_start),
    .descend   (descend),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .frame_len (frame_len),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready),
    .sm_tready (sm_tready),
    .sm_tvalid (sm_tvalid),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit precedes(input word_t a, input word_t b, input logic desc);
    return desc ? (a > b) : (a < b);
  endfunction

  // Model: a closed frame's expected output is just its words sorted by direction.
  function automatic void close_frame();
    word_t s[$];
    word_t key;
    int    j;
    s = cur_q;
    for (int i = 1; i < s.size(); i++) begin
      key = s[i];
      j   = i - 1;
      while (j >= 0 && precedes(key, s[j], model_desc)) begin
        s[j+1] = s[j];
        j--;
      end
      s[j+1] = key;
    end
    for (int i = 0; i < s.size(); i++)
      exp_q.push_back('{data: DATA_W'(s[i]), last: (i == s.size() - 1), len: s.size()});
    cur_q.delete();
  endfunction

  // Monitor/compare: sampled on the falling edge, once per cycle.
  always @(negedge axis_clk) begin
    if (axis_rst) begin
      cur_q.delete();
      exp_q.delete();
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
      prev_done    = 1'b0;
    end else begin
      if (ap_start) begin
        model_desc = descend;
        cur_q.delete();
      end
      if (ss_tvalid && ss_tready) begin
        cur_q.push_back(word_t'(ss_tdata));
        if (ss_tlast || cur_q.size() == DEPTH) close_frame();
      end
      check("ap_done", 64'(ap_done), 64'(prev_last_hs));
      if (prev_done) check("ap_idle_after_done", 64'(ap_idle), 64'd1);
      if (prev_stall) begin
        check("hold_valid", 64'(sm_tvalid), 64'd1);
        check("hold_data", 64'(sm_tdata), 64'(prev_data));
        check("hold_last", 64'(sm_tlast), 64'(prev_last));
      end
      cur_hs       = sm_tvalid && sm_tready;
      prev_last_hs = 1'b0;
      if (cur_hs) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no output", sm_tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(sm_tdata), 64'(e.data));
          check("out_last", 64'(sm_tlast), 64'(e.last));
          check("frame_len", 64'(frame_len), 64'(e.len));
          out_log.push_back(sm_tdata);
          prev_last_hs = e.last;
        end
      end
      prev_done  = ap_done;
      prev_stall = sm_tvalid && !sm_tready;
      prev_data  = sm_tdata;
      prev_last  = sm_tlast;
    end
  end

  // Output backpressure source: 30% ready duty when enabled.
  initial begin
    sm_tready = 1'b1;
    forever begin
      @(posedge axis_clk);
      #1;
      sm_tready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic start_frame(input logic desc);
    int k = 0;
    while (!ap_idle && k < 300) begin
      tick();
      k++;
    end
    if (!ap_idle) check("start_idle_timeout", 64'(ap_idle), 64'd1);
    ap_start = 1'b1;
    descend  = desc;
    tick();
    ap_start = 1'b0;
    descend  = ~desc;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      ss_tvalid = 1'b0;
      repeat (gap) tick();
    end
    ss_tvalid = 1'b1;
    ss_tdata  = d;
    ss_tlast  = l;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge axis_clk);
      if (ss_tready) begin
        @(posedge axis_clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic stream_idle();
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge axis_clk);
      if (ap_done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_log(input string name, input logic [DATA_W-1:0] ref_w [], input int n);
    check({name, "_count"}, 64'(out_log.size()), 64'(n));
    for (int i = 0; i < n && i < out_log.size(); i++)
      check(name, 64'(out_log[i]), 64'(ref_w[i]));
  endtask

  logic [DATA_W-1:0] t1_in  [10] = '{9, 3, 7, 1, 8, 2, 6, 0, 5, 4};
  logic [DATA_W-1:0] t3_in  [10] = '{40, 12, 33, 7, 25, 18, 3, 29, 11, 36};
  logic [DATA_W-1:0] sgn_in [4]  = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd0};
  logic [DATA_W-1:0] ref_w  [];

  initial begin
    axis_rst  = 1'b1;
    ap_start  = 1'b0;
    descend   = 1'b0;
    ss_tvalid = 1'b0;
    ss_tdata  = '0;
    ss_tlast  = 1'b0;
    repeat (3) tick();
    check("rst_ss_tready", 64'(ss_tready), 64'd0);
    check("rst_sm_tvalid", 64'(sm_tvalid), 64'd0);
    check("rst_sm_tdata", 64'(sm_tdata), 64'd0);
    check("rst_sm_tlast", 64'(sm_tlast), 64'd0);
    check("rst_ap_done", 64'(ap_done), 64'd0);
    check("rst_ap_idle", 64'(ap_idle), 64'd1);
    check("rst_frame_len", 64'(frame_len), 64'd0);
    axis_rst = 1'b0;
    tick();

    // Full ascending frame with latency checks.
    out_log.delete();
    start_frame(1'b0);
    check("load_ready", 64'(ss_tready), 64'd1);
    check("load_not_idle", 64'(ap_idle), 64'd0);
    for (int i = 0; i < 10; i++) send_word(t1_in[i], (i == 9), 0);
    stream_idle();
    for (int k = 0; k < DEPTH; k++) begin
      check("sort_no_valid", 64'(sm_tvalid), 64'd0);
      check("sort_no_ready", 64'(ss_tready), 64'd0);
      tick();
    end
    check("first_valid", 64'(sm_tvalid), 64'd1);
    wait_done();
    ref_w = new[10];
    for (int i = 0; i < 10; i++) ref_w[i] = DATA_W'(i);
    check_log("t1_out", ref_w, 10);

    // Short descending frame with input gaps.
    out_log.delete();
    start_frame(1'b1);
    send_word(32'd5, 1'b0, 1);
    send_word(32'd100, 1'b0, 2);
    send_word(32'd42, 1'b1, 0);
    stream_idle();
    wait_done();
    check("t2_frame_len", 64'(frame_len), 64'd3);
    ref_w = new[3];
    ref_w[0] = 32'd100; ref_w[1] = 32'd42; ref_w[2] = 32'd5;
    check_log("t2_out", ref_w, 3);

    // Overlong frame: truncated at DEPTH, surplus beats go to the next frame.
    out_log.delete();
    start_frame(1'b0);
    for (int i = 0; i < 10; i++) send_word(t3_in[i], 1'b0, 0);
    ss_tvalid = 1'b1;
    ss_tdata  = 32'd99;
    ss_tlast  = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 2000 && !seen; k++) begin
        @(negedge axis_clk);
        check("stall_ready", 64'(ss_tready), 64'd0);
        if (ap_done) seen = 1'b1;
      end
      check("t3_done_seen", 64'(seen), 64'd1);
    end
    tick();
    check("idle_no_ready", 64'(ss_tready), 64'd0);
    ref_w = new[10];
    ref_w[0] = 3;  ref_w[1] = 7;  ref_w[2] = 11; ref_w[3] = 12; ref_w[4] = 18;
    ref_w[5] = 25; ref_w[6] = 29; ref_w[7] = 33; ref_w[8] = 36; ref_w[9] = 40;
    check_log("t3_out", ref_w, 10);
    out_log.delete();
    start_frame(1'b0);
    send_word(32'd99, 1'b0, 0);
    send_word(32'd1, 1'b0, 0);
    send_word(32'd50, 1'b1, 0);
    stream_idle();
    wait_done();
    ref_w = new[3];
    ref_w[0] = 1; ref_w[1] = 50; ref_w[2] = 99;
    check_log("t3b_out", ref_w, 3);

    // Random backpressure with input gaps; the monitor checks every word.
    bp_en = 1'b1;
    out_log.delete();
    start_frame(1'b0);
    for (int i = 0; i < 10; i++) send_word($urandom, (i == 9), $urandom_range(0, 2));
    stream_idle();
    wait_done();
    check("t4a_count", 64'(out_log.size()), 64'd10);
    out_log.delete();
    start_frame(1'b1);
    for (int i = 0; i < 6; i++) send_word($urandom, (i == 5), $urandom_range(0, 2));
    stream_idle();
    wait_done();
    check("t4b_count", 64'(out_log.size()), 64'd6);
    bp_en = 1'b0;

    // Sign-sensitive ordering.
    out_log.delete();
    start_frame(1'b0);
    for (int i = 0; i < 4; i++) send_word(sgn_in[i], (i == 3), 0);
    stream_idle();
    wait_done();
    ref_w = new[4];
`ifdef STREAM_SORT_SIGNED_EN
    ref_w[0] = 32'h8000_0000; ref_w[1] = 32'hFFFF_FFFF; ref_w[2] = 32'd0; ref_w[3] = 32'd1;
`else
    ref_w[0] = 32'd0; ref_w[1] = 32'd1; ref_w[2] = 32'h8000_0000; ref_w[3] = 32'hFFFF_FFFF;
`endif
    check_log("t5_out", ref_w, 4);

    // Reset during sort pass 3, then a fresh frame.
    out_log.delete();
    start_frame(1'b0);
    for (int i = 0; i < 5; i++) send_word(DATA_W'(5 - i), (i == 4), 0);
    stream_idle();
    repeat (3) tick();
    axis_rst = 1'b1;
    tick();
    check("mid_rst_ss_tready", 64'(ss_tready), 64'd0);
    check("mid_rst_sm_tvalid", 64'(sm_tvalid), 64'd0);
    check("mid_rst_sm_tdata", 64'(sm_tdata), 64'd0);
    check("mid_rst_sm_tlast", 64'(sm_tlast), 64'd0);
    check("mid_rst_ap_done", 64'(ap_done), 64'd0);
    check("mid_rst_ap_idle", 64'(ap_idle), 64'd1);
    check("mid_rst_frame_len", 64'(frame_len), 64'd0);
    axis_rst = 1'b0;
    repeat (DEPTH + 4) tick();
    check("mid_rst_no_output", 64'(out_log.size()), 64'd0);
    start_frame(1'b0);
    send_word(32'd2, 1'b0, 0);
    send_word(32'd1, 1'b1, 0);
    stream_idle();
    wait_done();
    ref_w = new[2];
    ref_w[0] = 1; ref_w[1] = 2;
    check_log("t6_out", ref_w, 2);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
